// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-first bypass, hardwired zero
// register and a sequenced clear engine that initialises every entry after reset.
//
// state    | meaning
// ST_CLEAR | clear engine writing 0 to mem[clr_ptr]; accesses ignored, busy=1
// ST_RUN   | normal operation; reads and writes accepted
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 busy,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [DW-1:0]        wd,
  input  logic [NUM_RD-1:0]    re,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD*DW-1:0] rd,
  output logic [NUM_RD-1:0]    rd_valid
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_ptr, clr_ptr_nxt;
  logic [DW-1:0]     mem [DEPTH];
  logic              wr_ok;
  logic [AW-1:0]     ra_a   [NUM_RD];
  logic [DW-1:0]     rd_val [NUM_RD];
  logic [DW-1:0]     rd_q   [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        if (clr_ptr == LAST) begin
          state_nxt   = ST_RUN;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  assign busy = (state == ST_CLEAR);

  // Out-of-range and zero-register writes are squashed here so bypass never forwards them.
  assign wr_ok = (state == ST_RUN) && we && ({1'b0, wa} < DEPTH_W) &&
                 !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign ra_a[g]            = ra[g*AW +: AW];
    assign rd[g*DW +: DW]     = rd_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = '0;
      if (({1'b0, ra_a[i]} < DEPTH_W) && !((ZERO_REG != 0) && (ra_a[i] == '0))) begin
        if ((BYPASS != 0) && wr_ok && (wa == ra_a[i])) begin
          rd_val[i] = wd;
        end else begin
          rd_val[i] = mem[ra_a[i]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) rd_q[i] <= '0;
      rd_valid_q <= '0;
    end else if (state == ST_CLEAR) begin
      for (int i = 0; i < NUM_RD; i++) rd_q[i] <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (re[i]) rd_q[i] <= rd_val[i];
      end
      rd_valid_q <= re;
    end
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, read-old-value and 20-deep instances share one stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [1:0]  re;
  logic [9:0]  ra;

  logic        busy_a, busy_b, busy_c;
  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rdv_a, rdv_b, rdv_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_a), .rd_valid(rdv_a)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_b), .rd_valid(rdv_b)
  );

  regfile_mp #(.DEPTH(20)) dut_c (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_c), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_c), .rd_valid(rdv_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int na, nc;
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; wa = '0; wd = '0; re = '0; ra = '0;
    #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy_a); end
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd_a); end
    checks++; if (rdv_a !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b exp=00", rdv_a); end
    repeat (3) tick();
    rst = 1'b0;
    na = 0; nc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy_a && na == 0) na = i;
      if (!busy_c && nc == 0) nc = i;
      if (na != 0 && nc != 0) break;
    end
    checks++; if (na !== 32) begin errors++; $display("FAIL reset_clear32 got=%0d exp=32", na); end
    checks++; if (nc !== 20) begin errors++; $display("FAIL reset_clear20 got=%0d exp=20", nc); end
    re = 2'b11; ra = {5'd31, 5'd5};
    tick();
    re = 2'b00;
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL init_read got=%h exp=0", rd_a); end
    checks++; if (rdv_a !== 2'b11) begin errors++; $display("FAIL init_rdv got=%b exp=11", rdv_a); end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; re = 2'b00;
    tick();
    checks++; if (rdv_a !== 2'b00) begin errors++; $display("FAIL wr_rdv got=%b exp=00", rdv_a); end
    we = 1'b0; re = 2'b01; ra = {5'd0, 5'd7};
    tick();
    checks++; if (rd_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd7 got=%h exp=deadbeef", rd_a[31:0]); end
    checks++; if (rdv_a !== 2'b01) begin errors++; $display("FAIL rd7_rdv got=%b exp=01", rdv_a); end
    re = 2'b00; ra = {5'd0, 5'd2};
    tick();
    checks++; if (rd_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rd got=%h exp=deadbeef", rd_a[31:0]); end
    checks++; if (rdv_a !== 2'b00) begin errors++; $display("FAIL hold_rdv got=%b exp=00", rdv_a); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd3; wd = 32'h12345678; re = 2'b01; ra = {5'd0, 5'd3};
    tick();
    we = 1'b0;
    checks++; if (rd_a[31:0] !== 32'h12345678) begin errors++; $display("FAIL bypass1 got=%h exp=12345678", rd_a[31:0]); end
    checks++; if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL bypass0 got=%h exp=0", rd_b[31:0]); end
    tick();
    re = 2'b00;
    checks++; if (rd_b[31:0] !== 32'h12345678) begin errors++; $display("FAIL bypass0_after got=%h exp=12345678", rd_b[31:0]); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; re = 2'b11; ra = {5'd0, 5'd0};
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL zero_bypass got=%h exp=0", rd_a); end
    tick();
    re = 2'b00;
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL zero_read got=%h exp=0", rd_a); end
    checks++; if (rdv_a !== 2'b11) begin errors++; $display("FAIL zero_rdv got=%b exp=11", rdv_a); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 31; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i);
      re = 2'b10; ra = {5'(i - 1), 5'd0};
      tick();
      checks++;
      if (rd_a[63:32] !== 32'(i - 1)) begin
        errors++; $display("FAIL b2b_rd%0d got=%h exp=%h", i - 1, rd_a[63:32], 32'(i - 1));
      end
    end
    we = 1'b0; re = 2'b00;
  endtask

  task automatic test_clear();
    int n;
    re = 2'b01; ra = {5'd0, 5'd9};
    tick();
    checks++; if (rd_a[31:0] !== 32'd9) begin errors++; $display("FAIL pre_clear got=%h exp=9", rd_a[31:0]); end
    clr_req = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hAA; re = 2'b01;
    tick();
    clr_req = 1'b0; we = 1'b0; re = 2'b00;
    checks++; if (rd_a[31:0] !== 32'hAA) begin errors++; $display("FAIL clr_cycle_rd got=%h exp=aa", rd_a[31:0]); end
    checks++; if (rd_b[31:0] !== 32'd9) begin errors++; $display("FAIL clr_cycle_rd_nb got=%h exp=9", rd_b[31:0]); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL clr_busy got=%b exp=1", busy_a); end
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy_a) begin n = i; break; end
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL clr_len got=%0d exp=32", n); end
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL clr_rd_zero got=%h exp=0", rd_a); end
    re = 2'b11; ra = {5'd31, 5'd9};
    tick();
    re = 2'b00;
    checks++; if (rd_a !== 64'h0) begin errors++; $display("FAIL post_clear got=%h exp=0", rd_a); end
    checks++; if (rd_b !== 64'h0) begin errors++; $display("FAIL post_clear_nb got=%h exp=0", rd_b); end
  endtask

  task automatic test_depth20();
    int n;
    we = 1'b1; wa = 5'd25; wd = 32'h55; re = 2'b01; ra = {5'd0, 5'd25};
    tick();
    we = 1'b0;
    checks++; if (rd_c[31:0] !== 32'h0) begin errors++; $display("FAIL d20_oor_bypass got=%h exp=0", rd_c[31:0]); end
    checks++; if (rdv_c !== 2'b01) begin errors++; $display("FAIL d20_oor_rdv got=%b exp=01", rdv_c); end
    tick();
    checks++; if (rd_c[31:0] !== 32'h0) begin errors++; $display("FAIL d20_oor_read got=%h exp=0", rd_c[31:0]); end
    we = 1'b1; wa = 5'd19; wd = 32'h1919; re = 2'b00;
    tick();
    we = 1'b0; re = 2'b01; ra = {5'd0, 5'd19};
    tick();
    re = 2'b00;
    checks++; if (rd_c[31:0] !== 32'h1919) begin errors++; $display("FAIL d20_last got=%h exp=1919", rd_c[31:0]); end
    #3 rst = 1'b1;
    #1;
    checks++; if (rd_c[31:0] !== 32'h0) begin errors++; $display("FAIL async_rd got=%h exp=0", rd_c[31:0]); end
    checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL async_busy got=%b exp=1", busy_c); end
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy_c) begin n = i; break; end
    end
    checks++; if (n !== 20) begin errors++; $display("FAIL d20_clear got=%0d exp=20", n); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL d20_midclear_busy got=%b exp=1", busy_c); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy_c) begin n = i; break; end
    end
    checks++; if (n !== 20) begin errors++; $display("FAIL d20_restart got=%0d exp=20", n); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_depth20();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
